// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared opcode encodings (MIPS) and UART memory-map constants for the MMIO decoder.
package uart_mmio_ctrl_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [3:0] UART_REGION = 4'h8;

   localparam logic [3:0] UART_OFF_TX_CTRL = 4'h0;
   localparam logic [3:0] UART_OFF_RX_CTRL = 4'h4;
   localparam logic [3:0] UART_OFF_TX_DATA = 4'h8;
   localparam logic [3:0] UART_OFF_RX_DATA = 4'hC;

   typedef enum logic [1:0] {
      REG_TX_CTRL = UART_OFF_TX_CTRL[3:2],
      REG_RX_CTRL = UART_OFF_RX_CTRL[3:2],
      REG_TX_DATA = UART_OFF_TX_DATA[3:2],
      REG_RX_DATA = UART_OFF_RX_DATA[3:2]
   } uart_reg_e;

   function automatic logic is_load_op(input logic [5:0] op);
      return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
             (op == OP_LBU) || (op == OP_LHU);
   endfunction

   function automatic logic is_store_op(input logic [5:0] op);
      return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
   endfunction

endpackage

// File: rtl/uart_addr_decode.sv
// Classifies the memory-stage opcode and checks whether the address lands on
// a word-aligned UART register; bits [27:4] of the address are don't-care.
module uart_addr_decode
   import uart_mmio_ctrl_pkg::*;
(
   input  logic [3:0] addr_region,
   input  logic [3:0] addr_low,
   input  logic [5:0] opcode,
   output logic       is_load,
   output logic       is_store,
   output logic       hit,
   output uart_reg_e  reg_sel
);

   always_comb begin
      is_load  = is_load_op(opcode);
      is_store = is_store_op(opcode);
      hit      = (addr_region == UART_REGION) && (addr_low[1:0] == 2'b00) &&
                 (is_load || is_store);
      reg_sel  = uart_reg_e'(addr_low[3:2]);
   end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO access decoder: strobes TX/RX on stores/loads to the UART registers
// and steers the load-data path. Purely combinational; reset only forces idle outputs.
module uart_mmio_ctrl
   import uart_mmio_ctrl_pkg::*;
(
   input  logic        Clock,
   input  logic        Reset_n,
   input  logic [31:0] ALUOut,
   input  logic [5:0]  opcode,
   input  logic        DataInReady,
   input  logic        DataOutValid,
   input  logic [7:0]  UARTDataOut,
   output logic        DataInValid,
   output logic        DataOutReady,
   output logic [31:0] UARTCtrOut,
   output logic        UARTCtr
);

   logic      is_load;
   logic      is_store;
   logic      hit;
   uart_reg_e reg_sel;

   // The clock is kept only so this block drops into the same port shape as its peers.
   logic unused_clock;
   assign unused_clock = Clock;

   uart_addr_decode u_decode (
      .addr_region (ALUOut[31:28]),
      .addr_low    (ALUOut[3:0]),
      .opcode      (opcode),
      .is_load     (is_load),
      .is_store    (is_store),
      .hit         (hit),
      .reg_sel     (reg_sel)
   );

   always_comb begin
      DataInValid  = 1'b0;
      DataOutReady = 1'b0;
      UARTCtr      = 1'b0;
      UARTCtrOut   = ALUOut;
      if (Reset_n && hit) begin
         if (is_load) begin
            case (reg_sel)
               REG_TX_CTRL: begin
                  UARTCtrOut = {31'b0, DataInReady};
                  UARTCtr    = 1'b1;
               end
               REG_RX_CTRL: begin
                  UARTCtrOut = {31'b0, DataOutValid};
                  UARTCtr    = 1'b1;
               end
               REG_RX_DATA: begin
                  // Load width/sign are ignored: the received byte is always zero-extended.
                  UARTCtrOut   = {24'b0, UARTDataOut};
                  UARTCtr      = 1'b1;
                  DataOutReady = 1'b1;
               end
               default: ;
            endcase
         end else if (is_store && (reg_sel == REG_TX_DATA)) begin
            DataInValid = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: literal expectations per vector plus an
// address-arithmetic reference model compared on every falling clock edge.
module tb_uart_mmio_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] alu_out = 32'h0;
   logic [5:0]  opcode = 6'h00;
   logic        data_in_ready = 1'b0;
   logic        data_out_valid = 1'b0;
   logic [7:0]  uart_data_out = 8'h00;
   logic        data_in_valid;
   logic        data_out_ready;
   logic [31:0] uart_ctr_out;
   logic        uart_ctr;

   int n_checks = 0;
   int n_fails  = 0;

   localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
   localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B, ADDIU = 6'h09;

   always #5 clk = ~clk;

   uart_mmio_ctrl dut (
      .Clock        (clk),
      .Reset_n      (rst_n),
      .ALUOut       (alu_out),
      .opcode       (opcode),
      .DataInReady  (data_in_ready),
      .DataOutValid (data_out_valid),
      .UARTDataOut  (uart_data_out),
      .DataInValid  (data_in_valid),
      .DataOutReady (data_out_ready),
      .UARTCtrOut   (uart_ctr_out),
      .UARTCtr      (uart_ctr)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: reasons about the address as a number and the opcode as set membership.
   function automatic void model(input logic rn, input logic [31:0] a, input logic [5:0] op,
                                 input logic rdy, input logic vld, input logic [7:0] rx,
                                 output logic e_div, output logic e_dor,
                                 output logic e_ctr, output logic [31:0] e_out);
      int unsigned loads[5];
      int unsigned stores[3];
      bit is_ld, is_st, in_uart;
      int unsigned regno;
      loads  = '{32'h20, 32'h21, 32'h23, 32'h24, 32'h25};
      stores = '{32'h28, 32'h29, 32'h2B};
      is_ld = 0;
      is_st = 0;
      foreach (loads[i])  if (loads[i]  == 32'(op)) is_ld = 1;
      foreach (stores[i]) if (stores[i] == 32'(op)) is_st = 1;
      in_uart = (a / 32'h1000_0000 == 8) && (a % 4 == 0) && (rn == 1'b1);
      regno = (a / 4) % 4;
      e_div = 0;
      e_dor = 0;
      e_ctr = 0;
      e_out = a;
      if (in_uart && is_ld && regno != 2) begin
         e_ctr = 1;
         if (regno == 0) e_out = rdy ? 32'd1 : 32'd0;
         else if (regno == 1) e_out = vld ? 32'd1 : 32'd0;
         else begin
            e_out = 32'(rx);
            e_dor = 1;
         end
      end
      if (in_uart && is_st && regno == 2) e_div = 1;
   endfunction

   always @(negedge clk) begin
      logic e_div, e_dor, e_ctr;
      logic [31:0] e_out;
      model(rst_n, alu_out, opcode, data_in_ready, data_out_valid, uart_data_out,
            e_div, e_dor, e_ctr, e_out);
      check("model_DataInValid", 32'(data_in_valid), 32'(e_div));
      check("model_DataOutReady", 32'(data_out_ready), 32'(e_dor));
      check("model_UARTCtr", 32'(uart_ctr), 32'(e_ctr));
      check("model_UARTCtrOut", uart_ctr_out, e_out);
      check("model_onehot_strobes", 32'(data_in_valid & data_out_ready), 32'd0);
   end

   // Presents one vector just after a rising edge and checks hand-computed literals.
   task automatic apply(input string name, input logic [31:0] a, input logic [5:0] op,
                        input logic rdy, input logic vld, input logic [7:0] rx,
                        input logic x_div, input logic x_dor, input logic x_ctr,
                        input logic [31:0] x_out);
      @(posedge clk);
      #1;
      alu_out = a;
      opcode = op;
      data_in_ready = rdy;
      data_out_valid = vld;
      uart_data_out = rx;
      #1;
      check({name, "_DataInValid"}, 32'(data_in_valid), 32'(x_div));
      check({name, "_DataOutReady"}, 32'(data_out_ready), 32'(x_dor));
      check({name, "_UARTCtr"}, 32'(uart_ctr), 32'(x_ctr));
      check({name, "_UARTCtrOut"}, uart_ctr_out, x_out);
      $display("txn %-14s addr=0x%08h op=0x%02h -> div=%0b dor=%0b ctr=%0b out=0x%08h",
               name, a, op, data_in_valid, data_out_ready, uart_ctr, uart_ctr_out);
   endtask

   initial begin
      // Reset asserted with an RX-data load presented: everything idle, address passes through.
      rst_n = 1'b0;
      apply("reset_idle", 32'h8000000C, LW, 1'b1, 1'b1, 8'h5A, 0, 0, 0, 32'h8000000C);
      @(posedge clk);
      #1 rst_n = 1'b1;

      apply("non_uart",     32'h0FFFFFFF, ADDIU, 1'b1, 1'b1, 8'hFF, 0, 0, 0, 32'h0FFFFFFF);
      apply("sw_rx_ctrl",   32'h80000004, SW,    1'b1, 1'b1, 8'h11, 0, 0, 0, 32'h80000004);
      apply("sw_misalign",  32'h80000007, SW,    1'b1, 1'b1, 8'h11, 0, 0, 0, 32'h80000007);
      apply("lw_txctl_rdy", 32'h8FFFFFF0, LW,    1'b1, 1'b0, 8'h00, 0, 0, 1, 32'h00000001);
      apply("lw_txctl_bsy", 32'h8FFFFFF0, LW,    1'b0, 1'b1, 8'h00, 0, 0, 1, 32'h00000000);
      apply("lb_rxctl_emp", 32'h8FFFFFF4, LB,    1'b1, 1'b0, 8'h33, 0, 0, 1, 32'h00000000);
      apply("lb_rxctl_val", 32'h8FFFFFF4, LB,    1'b0, 1'b1, 8'h33, 0, 0, 1, 32'h00000001);
      apply("sb_txdata",    32'h8FFFFFF8, SB,    1'b0, 1'b0, 8'h00, 1, 0, 0, 32'h8FFFFFF8);
      apply("sh_txdata",    32'h80000008, SH,    1'b1, 1'b1, 8'h77, 1, 0, 0, 32'h80000008);
      apply("lh_txdata",    32'h80000008, LH,    1'b1, 1'b1, 8'h77, 0, 0, 0, 32'h80000008);
      apply("lbu_rxdata",   32'h80000ABC, LBU,   1'b0, 1'b1, 8'h80, 0, 1, 1, 32'h00000080);
      apply("sw_rxdata",    32'h8000000C, SW,    1'b1, 1'b1, 8'h42, 0, 0, 0, 32'h8000000C);
      apply("sw_region9",   32'h90000008, SW,    1'b1, 1'b1, 8'h42, 0, 0, 0, 32'h90000008);
      apply("lw_misalign",  32'h8000000E, LW,    1'b1, 1'b1, 8'h42, 0, 0, 0, 32'h8000000E);
      apply("addiu_txdata", 32'h80000008, ADDIU, 1'b1, 1'b1, 8'h42, 0, 0, 0, 32'h80000008);

      // RX data load, then reset dropped mid-access with no clock edge in between.
      apply("lhu_rxdata",   32'h8FFFFFFC, LHU,   1'b0, 1'b0, 8'hC4, 0, 1, 1, 32'h000000C4);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_DataOutReady", 32'(data_out_ready), 32'd0);
      check("async_rst_DataInValid", 32'(data_in_valid), 32'd0);
      check("async_rst_UARTCtr", 32'(uart_ctr), 32'd0);
      check("async_rst_UARTCtrOut", uart_ctr_out, 32'h8FFFFFFC);
      $display("txn %-14s addr=0x%08h op=0x%02h -> div=%0b dor=%0b ctr=%0b out=0x%08h",
               "async_reset", alu_out, opcode, data_in_valid, data_out_ready, uart_ctr, uart_ctr_out);
      @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
      check("rst_release_DataOutReady", 32'(data_out_ready), 32'd1);
      check("rst_release_UARTCtrOut", uart_ctr_out, 32'h000000C4);

      apply("idle_end",     32'h00000000, 6'h00, 1'b0, 1'b0, 8'h00, 0, 0, 0, 32'h00000000);
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped UART access decoder between the CPU datapath (ALU address plus opcode) and the UART transmitter/receiver ready/valid ports. It recognises loads and stores to the four UART registers. For stores it strobes the transmitter. For loads it strobes the receiver, muxes the register value onto the load-data path, and flags that the load result comes from the UART rather than data memory.

## Interface
- No parameters. Opcode encodings come from the shared opcode header (`LB`, `LH`, `LW`, `LBU`, `LHU`, `SB`, `SH`, `SW`, MIPS encodings).
- `Clock` input 1: system clock. No sequential state depends on it; it is kept for interface uniformity.
- `Reset_n` input 1: one clock; reset is asynchronous and active-low.
- `ALUOut` input 32: effective address computed by the ALU.
- `opcode` input 6: opcode of the instruction in the memory stage.
- `DataInReady` input 1: UART transmitter can accept a byte.
- `DataOutValid` input 1: UART receiver holds a valid byte.
- `UARTDataOut` input 8: byte held by the UART receiver.
- `DataInValid` output 1: push strobe to the transmitter.
- `DataOutReady` output 1: pop/acknowledge strobe to the receiver.
- `UARTCtrOut` output 32: UART read data when `UARTCtr`=1; otherwise `ALUOut` passed through.
- `UARTCtr` output 1: load-data select; 1 means the writeback value is `UARTCtrOut`.

## Operation
- UART region hit: `ALUOut[31:28]`==4'h8 and `ALUOut[1:0]`==2'b00. Bits [27:4] are don't-care, so 0x80000004 and 0x8FFFFFF4 decode identically.
- Register select is `ALUOut[3:2]`:
  - 00 TX control, read-only.
  - 01 RX control, read-only.
  - 10 TX data, write-only.
  - 11 RX data, read-only.
- Load class is `LB`, `LH`, `LW`, `LBU`, `LHU`. Store class is `SB`, `SH`, `SW`. All other opcodes never hit.
- Load from TX control: `UARTCtrOut`={31'b0, `DataInReady`}, `UARTCtr`=1.
- Load from RX control: `UARTCtrOut`={31'b0, `DataOutValid`}, `UARTCtr`=1.
- Load from RX data: `UARTCtrOut`={24'b0, `UARTDataOut`}, `UARTCtr`=1, `DataOutReady`=1. Load width and sign are ignored; the result is always zero-extended.
- Store to TX data: `DataInValid`=1, `UARTCtr`=0, `UARTCtrOut`=`ALUOut`. The byte to transmit is taken by the transmitter directly from the store-data path, not from this block.
- Store to a read-only register, load from TX data, misaligned or non-UART address, non-memory opcode: no strobes, `UARTCtr`=0, `UARTCtrOut`=`ALUOut`.
- The strobes are never gated by the ready/valid inputs. Software polls the control registers first.
- At most one of `DataInValid`, `DataOutReady` is high at any time.

## Timing
- Fully combinational from `ALUOut`, `opcode`, and the UART inputs to all outputs. Zero latency, settled within the same cycle.
- Strobes are level signals, high for every cycle the qualifying instruction is presented. The pipeline presents each memory instruction for exactly one cycle.
- `Reset_n` low (asynchronous, immediate):
  - `DataInValid`=0, `DataOutReady`=0, `UARTCtr`=0.
  - `UARTCtrOut`=`ALUOut`.
- Normal decode resumes combinationally on `Reset_n` release. No state needs recovery.

## Structure
- Region nibble (4'h8), register offsets (0x0, 0x4, 0x8, 0xC), and load/store opcode lists belong in the shared opcode/memory-map package or header.
- One natural sub-module: `uart_addr_decode`, producing `is_load`, `is_store`, `hit`, and the 2-bit register select. The top level holds the output mux and strobe logic.

## Test plan
- Non-UART access: `ALUOut`=0x0FFFFFFF, `opcode`=`ADDIU` -> all strobes 0, `UARTCtr`=0, `UARTCtrOut`=0x0FFFFFFF.
- Store to read-only register: `SW` to 0x80000004, then to 0x80000007 -> no strobes, `UARTCtr`=0, `UARTCtrOut`=`ALUOut`.
- TX control load: `LW` 0x8FFFFFF0, `DataInReady`=1 -> `UARTCtrOut`=0x00000001, `UARTCtr`=1, strobes 0. Repeat with `DataInReady`=0 -> 0x00000000.
- RX control load: `LB` 0x8FFFFFF4, `DataOutValid`=0 -> `UARTCtrOut`=0, `UARTCtr`=1, strobes 0. With `DataOutValid`=1 -> 0x00000001.
- TX data store: `SB` 0x8FFFFFF8 -> `DataInValid`=1, `DataOutReady`=0, `UARTCtr`=0, `UARTCtrOut`=0x8FFFFFF8.
- RX data load: `LHU` 0x8FFFFFFC, `UARTDataOut`=0xC4 -> `DataOutReady`=1, `DataInValid`=0, `UARTCtrOut`=0x000000C4, `UARTCtr`=1. Assert `Reset_n`=0 mid-access -> `DataOutReady`=0, `UARTCtr`=0, `UARTCtrOut`=0x8FFFFFFC, with no clock edge needed.
